// File: rtl/parameters_pkg.sv
// Stage encodings broadcast from the context scheduler to every PE.
// Shared by the scheduler, the PE array and any bench that decodes global_stage.
package parameters_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM       = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;

endpackage

// File: rtl/context_stage_scheduler.sv
// Sequences LOAD, GROW/MERGE passes and PEEL over time-multiplexed decoding contexts,
// broadcasting a registered stage, context id and memory-switch qualifier to the PE array.
module context_stage_scheduler
  import parameters_pkg::*;
#(
  parameter int unsigned NUM_CONTEXTS = 2,
  parameter int unsigned CTX_WIDTH    = 1,
  parameter int unsigned MERGE_SETTLE = 3,
  parameter int unsigned MAX_GROW     = 63,
  parameter int unsigned ITER_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic                   cfg_local_switch,
  input  logic                   busy_any,
  input  logic                   odd_any,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   local_context_switch,
  output logic [CTX_WIDTH-1:0]   context_id,
  output logic [ITER_WIDTH-1:0]  iteration,
  output logic                   result_valid,
  output logic                   overflow,
  output logic                   done
);

  localparam int SETTLE_W = $clog2(MERGE_SETTLE + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_MEAS,
    S_LOAD_WR,
    S_GROW_RD0,
    S_GROW_RD1,
    S_GROW,
    S_MERGE,
    S_GROW_WR,
    S_PEEL_RD0,
    S_PEEL_RD1,
    S_PEELING,
    S_PEEL_WR,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [STAGE_WIDTH-1:0]  r_stage;
  logic [CTX_WIDTH-1:0]    r_ctx;
  logic [CTX_WIDTH-1:0]    w_ctx_next;
  logic [CTX_WIDTH-1:0]    w_ctx_inc;
  logic [ITER_WIDTH-1:0]   r_iter;
  logic [ITER_WIDTH-1:0]   w_iter_next;
  logic [ITER_WIDTH-1:0]   w_iter_inc;
  logic                    r_ovf;
  logic                    w_ovf_next;
  logic [NUM_CONTEXTS-1:0] r_conv;
  logic [NUM_CONTEXTS-1:0] w_conv_next;
  logic [SETTLE_W-1:0]     r_settle;
  logic [SETTLE_W-1:0]     w_settle_next;
  logic                    r_cfg;
  logic                    w_cfg_next;
  logic                    r_lcs;
  logic                    w_lcs_next;
  logic                    r_rv;
  logic                    r_done;
  logic                    w_last_ctx;

  function automatic logic [STAGE_WIDTH-1:0] stage_of(input state_t s);
    case (s)
      S_LOAD_MEAS:                                 return STAGE_MEASUREMENT_LOADING;
      S_LOAD_WR, S_GROW_WR, S_PEEL_WR:             return STAGE_WRITE_TO_MEM;
      S_GROW_RD0, S_GROW_RD1, S_PEEL_RD0, S_PEEL_RD1: return STAGE_READ_FROM_MEM;
      S_GROW:                                      return STAGE_GROW;
      S_MERGE:                                     return STAGE_MERGE;
      S_PEELING:                                   return STAGE_PEELING;
      default:                                     return STAGE_IDLE;
    endcase
  endfunction

  assign w_last_ctx = (r_ctx == CTX_WIDTH'(NUM_CONTEXTS - 1));
  assign w_ctx_inc  = w_last_ctx ? '0 : r_ctx + CTX_WIDTH'(1);
  assign w_iter_inc = (&r_iter) ? r_iter : r_iter + ITER_WIDTH'(1);

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_ctx_next    = r_ctx;
    w_iter_next   = r_iter;
    w_ovf_next    = r_ovf;
    w_conv_next   = r_conv;
    w_settle_next = r_settle;
    w_cfg_next    = r_cfg;

    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_state_next = S_LOAD_MEAS;
          w_ctx_next   = '0;
          w_iter_next  = '0;
          w_ovf_next   = 1'b0;
          w_conv_next  = '0;
          w_cfg_next   = cfg_local_switch;
        end
      end
      S_LOAD_MEAS: w_state_next = S_LOAD_WR;
      S_LOAD_WR: begin
        w_ctx_next   = w_ctx_inc;
        w_state_next = w_last_ctx ? S_GROW_RD0 : S_LOAD_MEAS;
      end
      S_GROW_RD0: w_state_next = S_GROW_RD1;
      // Converged contexts still do a read/write pair so PE memory pointers stay aligned.
      S_GROW_RD1: w_state_next = r_conv[r_ctx] ? S_GROW_WR : S_GROW;
      S_GROW: begin
        w_state_next  = S_MERGE;
        w_settle_next = '0;
      end
      S_MERGE: begin
        if (busy_any) begin
          w_settle_next = '0;
        end else if (r_settle == SETTLE_W'(MERGE_SETTLE - 1)) begin
          w_state_next = S_GROW_WR;
          if (!odd_any) w_conv_next[r_ctx] = 1'b1;
        end else begin
          w_settle_next = r_settle + SETTLE_W'(1);
        end
      end
      S_GROW_WR: begin
        w_ctx_next   = w_ctx_inc;
        w_state_next = S_GROW_RD0;
        if (w_last_ctx) begin
          w_iter_next = w_iter_inc;
          if (&r_conv) begin
            w_state_next = S_PEEL_RD0;
          end else if (w_iter_inc == ITER_WIDTH'(MAX_GROW)) begin
            w_ovf_next   = 1'b1;
            w_state_next = S_PEEL_RD0;
          end
        end
      end
      S_PEEL_RD0: w_state_next = S_PEEL_RD1;
      S_PEEL_RD1: w_state_next = S_PEELING;
      S_PEELING:  w_state_next = S_PEEL_WR;
      S_PEEL_WR: begin
        w_ctx_next   = w_ctx_inc;
        w_state_next = w_last_ctx ? S_DONE : S_PEEL_RD0;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Two-context ping-pong: write-back of context 0 and fetch of context 1 use the alternate bank.
    w_lcs_next = w_cfg_next && (NUM_CONTEXTS == 2) &&
                 (((w_state_next inside {S_GROW_WR, S_PEEL_WR}) && (w_ctx_next == '0)) ||
                  ((w_state_next inside {S_GROW_RD0, S_GROW_RD1, S_PEEL_RD0, S_PEEL_RD1}) &&
                   (w_ctx_next == CTX_WIDTH'(1))));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the converged vector is a few flops rather than a RAM, so it is cleared by reset like the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage  <= STAGE_IDLE;
      r_ctx    <= '0;
      r_iter   <= '0;
      r_ovf    <= 1'b0;
      r_conv   <= '0;
      r_settle <= '0;
      r_cfg    <= 1'b0;
      r_lcs    <= 1'b0;
      r_rv     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_stage  <= stage_of(w_state_next);
      r_ctx    <= w_ctx_next;
      r_iter   <= w_iter_next;
      r_ovf    <= w_ovf_next;
      r_conv   <= w_conv_next;
      r_settle <= w_settle_next;
      r_cfg    <= w_cfg_next;
      r_lcs    <= w_lcs_next;
      r_rv     <= (w_state_next == S_PEELING);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  assign start_ready          = (r_state == S_IDLE);
  assign global_stage         = r_stage;
  assign local_context_switch = r_lcs;
  assign context_id           = r_ctx;
  assign iteration            = r_iter;
  assign result_valid         = r_rv;
  assign overflow             = r_ovf;
  assign done                 = r_done;

endmodule

// File: tb/tb_context_stage_scheduler.sv
// Self-checking bench: a round-level model expands each scenario into a per-cycle table of
// {inputs, expected outputs}, which is then driven and compared cycle by cycle.
module tb_context_stage_scheduler;
  import parameters_pkg::*;

  localparam int NUM_CTX  = 2;
  localparam int SETTLE   = 3;
  localparam int MAX_GROW = 4;
  localparam int IW       = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start_valid;
  logic                   start_ready;
  logic                   cfg_local_switch;
  logic                   busy_any;
  logic                   odd_any;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   local_context_switch;
  logic [0:0]             context_id;
  logic [IW-1:0]          iteration;
  logic                   result_valid;
  logic                   overflow;
  logic                   done;

  context_stage_scheduler #(
    .NUM_CONTEXTS(NUM_CTX),
    .CTX_WIDTH   (1),
    .MERGE_SETTLE(SETTLE),
    .MAX_GROW    (MAX_GROW),
    .ITER_WIDTH  (IW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_valid         (start_valid),
    .start_ready         (start_ready),
    .cfg_local_switch    (cfg_local_switch),
    .busy_any            (busy_any),
    .odd_any             (odd_any),
    .global_stage        (global_stage),
    .local_context_switch(local_context_switch),
    .context_id          (context_id),
    .iteration           (iteration),
    .result_valid        (result_valid),
    .overflow            (overflow),
    .done                (done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic                   sv;
    logic                   cfg;
    logic                   busy;
    logic                   odd;
    logic [STAGE_WIDTH-1:0] stage;
    logic                   ctx;
    logic                   lcs;
    logic [IW-1:0]          iter;
    logic                   rv;
    logic                   ovf;
    logic                   dn;
    logic                   rdy;
  } vec_t;

  vec_t        q[$];
  int          m_iter;
  logic        m_ovf;
  int          n_checks = 0;
  int          n_errors = 0;
  int          obs_rv_seq;
  int          first_merge_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_exp(input vec_t v);
    return 32'({v.stage, v.ctx, v.lcs, v.iter, v.rv, v.ovf, v.dn, v.rdy});
  endfunction

  function automatic logic [31:0] pack_obs();
    return 32'({global_stage, context_id, local_context_switch, iteration,
                result_valid, overflow, done, start_ready});
  endfunction

  // One expected cycle; inputs are random noise unless the caller overrides them.
  function automatic vec_t mk(input logic [STAGE_WIDTH-1:0] st, input int c, input bit lcs,
                              input bit rv, input bit dn, input bit rdy);
    vec_t v;
    v.sv    = 1'($urandom_range(0, 1));
    v.cfg   = 1'($urandom_range(0, 1));
    v.busy  = 1'($urandom_range(0, 1));
    v.odd   = 1'($urandom_range(0, 1));
    v.stage = st;
    v.ctx   = 1'(c);
    v.lcs   = lcs;
    v.iter  = IW'(m_iter);
    v.rv    = rv;
    v.ovf   = m_ovf;
    v.dn    = dn;
    v.rdy   = rdy;
    return v;
  endfunction

  // odd_any at the end of MERGE for (pass, context): 0 converges that context.
  function automatic logic want_odd(input int mode, input int pass, input int c);
    case (mode)
      0:       return 1'b0;
      1:       return 1'($urandom_range(0, 1));
      2:       return 1'b1;
      default: return (c == 1 && pass < 3);
    endcase
  endfunction

  // Round model: builds the full expected cycle table from the decoding rules.
  task automatic build_round(input bit cfg, input int odd_mode, input int busy_mode);
    bit   conv[NUM_CTX];
    bit   lcs_on;
    bit   all_conv;
    int   pass;
    int   zeros;
    int   mcyc;
    vec_t v;
    q.delete();
    m_iter = 0;
    m_ovf  = 1'b0;
    lcs_on = cfg && (NUM_CTX == 2);
    for (int c = 0; c < NUM_CTX; c++) conv[c] = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) begin
      q.push_back(mk(STAGE_MEASUREMENT_LOADING, c, 0, 0, 0, 0));
      q.push_back(mk(STAGE_WRITE_TO_MEM, c, 0, 0, 0, 0));
    end
    pass = 0;
    forever begin
      for (int c = 0; c < NUM_CTX; c++) begin
        q.push_back(mk(STAGE_READ_FROM_MEM, c, lcs_on && c == 1, 0, 0, 0));
        q.push_back(mk(STAGE_READ_FROM_MEM, c, lcs_on && c == 1, 0, 0, 0));
        if (!conv[c]) begin
          q.push_back(mk(STAGE_GROW, c, 0, 0, 0, 0));
          zeros = 0;
          mcyc  = 0;
          while (zeros < SETTLE) begin
            v = mk(STAGE_MERGE, c, 0, 0, 0, 0);
            case (busy_mode)
              0:       v.busy = ($urandom_range(0, 2) == 0);
              1:       v.busy = (mcyc < 5);
              default: v.busy = 1'b0;
            endcase
            zeros = v.busy ? 0 : zeros + 1;
            mcyc++;
            if (zeros == SETTLE) begin
              v.odd = want_odd(odd_mode, pass, c);
              if (!v.odd) conv[c] = 1'b1;
            end
            q.push_back(v);
          end
        end
        q.push_back(mk(STAGE_WRITE_TO_MEM, c, lcs_on && c == 0, 0, 0, 0));
      end
      m_iter = (m_iter == (1 << IW) - 1) ? m_iter : m_iter + 1;
      pass++;
      all_conv = 1'b1;
      for (int c = 0; c < NUM_CTX; c++) all_conv &= conv[c];
      if (all_conv) break;
      if (m_iter == MAX_GROW) begin
        m_ovf = 1'b1;
        break;
      end
    end
    for (int c = 0; c < NUM_CTX; c++) begin
      q.push_back(mk(STAGE_READ_FROM_MEM, c, lcs_on && c == 1, 0, 0, 0));
      q.push_back(mk(STAGE_READ_FROM_MEM, c, lcs_on && c == 1, 0, 0, 0));
      q.push_back(mk(STAGE_PEELING, c, 0, 1, 0, 0));
      q.push_back(mk(STAGE_WRITE_TO_MEM, c, lcs_on && c == 0, 0, 0, 0));
    end
    q.push_back(mk(STAGE_IDLE, 0, 0, 0, 1, 0));
    v    = mk(STAGE_IDLE, 0, 0, 0, 0, 1);
    v.sv = 1'b0;
    q.push_back(v);
  endtask

  // Starts a round from IDLE (bench sits #1 after a rising edge) and compares every cycle.
  task automatic apply_round(input string tag, input bit cfg);
    bit in_first;
    obs_rv_seq      = 0;
    first_merge_len = 0;
    in_first        = 1'b1;
    start_valid      = 1'b1;
    cfg_local_switch = cfg;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_cyc%0d", tag, i), pack_obs(), pack_exp(q[i]));
      if (result_valid) obs_rv_seq = obs_rv_seq * 4 + int'(context_id) + 1;
      if (global_stage == STAGE_MERGE && in_first) first_merge_len++;
      else if (first_merge_len > 0) in_first = 1'b0;
      start_valid      = q[i].sv;
      cfg_local_switch = q[i].cfg;
      busy_any         = q[i].busy;
      odd_any          = q[i].odd;
    end
  endtask

  initial begin
    vec_t idle_v;
    bit   found;
    bit   cfg;

    reset            = 1'b1;
    start_valid      = 1'b1;
    cfg_local_switch = 1'b1;
    busy_any         = 1'b1;
    odd_any          = 1'b1;
    m_iter           = 0;
    m_ovf            = 1'b0;
    idle_v           = mk(STAGE_IDLE, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack_obs(), pack_exp(idle_v));
    reset       = 1'b0;
    start_valid = 1'b0;

    // Basic single-pass round: LOAD, one GROW pass, PEEL, done.
    build_round(0, 0, 2);
    apply_round("A", 0);
    check("A_iteration", 32'(iteration), 32'd1);
    check("A_overflow", 32'(overflow), 32'd0);
    check("A_rv_order", 32'(obs_rv_seq), 32'd6);

    // busy_any high for the first 5 MERGE cycles, with local switching enabled.
    build_round(1, 0, 1);
    apply_round("B", 1);
    check("B_merge_len", 32'(first_merge_len), 32'd8);

    // Context 1 stays odd for 3 passes; context 0 converges in pass 1.
    build_round(0, 3, 2);
    apply_round("C", 0);
    check("C_iteration", 32'(iteration), 32'd4);
    check("C_overflow", 32'(overflow), 32'd0);

    // odd_any stuck high: forced exit at MAX_GROW.
    build_round(1, 2, 0);
    apply_round("D", 1);
    check("D_iteration", 32'(iteration), 32'd4);
    check("D_overflow", 32'(overflow), 32'd1);

    for (int r = 0; r < 6; r++) begin
      cfg = 1'($urandom_range(0, 1));
      build_round(cfg, 1, 0);
      apply_round($sformatf("R%0d", r), cfg);
    end

    // Reset in the middle of a MERGE of a later pass.
    start_valid      = 1'b1;
    cfg_local_switch = 1'b1;
    odd_any          = 1'b1;
    busy_any         = 1'b0;
    found            = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      if (global_stage == STAGE_MERGE && iteration >= 2) begin
        found = 1'b1;
        break;
      end
    end
    check("merge_reached", 32'(found), 32'd1);
    busy_any = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midround_reset", pack_obs(), pack_exp(idle_v));

    build_round(1, 1, 0);
    apply_round("E", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
